opcode_map_lookup: RTL and testbench
====================================

# opcode_map_lookup

Parametrised, programmable opcode-map decode stage for the x86 front end. It consumes opcode bytes (prefixes already stripped) one per cycle over a valid/ready handshake and tracks the 0F / 0F38 / 0F3A escape sequences. It looks up a runtime-writable table of {class, has_modrm, imm_size} for each of four opcode maps and emits one registered decode record per complete opcode. It replaces the fixed, initial-block two-byte mnemonic/ModRM tables with a single table covering all maps that software or the bench loads through a config port.

## Interface
- CLASS_W, default 8: width of the mnemonic class code; class 0 means NULL/undefined opcode.
- ESC_EN, default 1: 1 = 0F38/0F3A three-byte maps enabled; 0 = bytes 38/3A after 0F are looked up in map 1 like any other opcode.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort: drops the partial escape sequence and any held output.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- in_byte  in  8  opcode byte.
- cfg_we  in  1  table write strobe.
- cfg_map  in  2  map select: 0 = one-byte, 1 = 0F, 2 = 0F38, 3 = 0F3A.
- cfg_opcode  in  8  entry index.
- cfg_class  in  CLASS_W  class code to write.
- cfg_modrm  in  1  ModRM byte follows.
- cfg_imm  in  2  immediate size code: 0 = none, 1 = 1 B, 2 = 2 B, 3 = 4 B.
- out_valid  out  1  decode record valid.
- out_ready  in  1  consumer accepts the record.
- out_map  out  2  map of the decoded opcode.
- out_opcode  out  8  final opcode byte.
- out_class  out  CLASS_W  table class.
- out_modrm  out  1  table ModRM flag.
- out_imm  out  2  table immediate code.
- out_nbytes  out  2  opcode bytes consumed: 1, 2 or 3.
- out_null  out  1  out_class == 0.

## Operation
- Table: 4×256 entries of {class, modrm, imm}. All entries are cleared to 0 on reset.
- Table reads are combinational. A cfg_we write lands at the clock edge.
- A lookup in the same cycle as a write to the same entry returns the old contents.
- FSM states: S_OP, S_0F, S_38, S_3A. Reset state is S_OP.
- S_OP, byte 0F: go to S_0F, no output.
- S_OP, any other byte: look up map 0, nbytes = 1.
- S_0F, byte 38 with ESC_EN = 1: go to S_38.
- S_0F, byte 3A with ESC_EN = 1: go to S_3A.
- S_0F, any other byte: look up map 1, nbytes = 2, return to S_OP.
- S_38 / S_3A: look up map 2 / map 3, nbytes = 3, return to S_OP.
- in_ready = !out_valid | out_ready. This rule applies to escape bytes as well.
- A lookup-producing byte loads the output register and sets out_valid.
- When out_valid & out_ready with no new record, out_valid clears.
- When the record is consumed and a new one loads in the same cycle, out_valid stays 1 and the data is replaced.
- flush forces the FSM to S_OP and clears out_valid.
  - A byte presented during flush is discarded.
  - cfg writes still apply during flush.
- Consecutive 0F bytes: in S_0F, 0F is looked up as a map-1 opcode (0F 0F), not as a second escape.

## Timing
- Reset values: out_valid 0; out_map, out_opcode, out_class, out_modrm, out_imm, out_null all 0; out_nbytes 0; FSM in S_OP.
- in_ready is 1 out of reset.
- Latency: the record is visible the cycle after the final opcode byte is accepted.
- Throughput: 1 byte/cycle with no backpressure, so one-byte opcodes produce one record per cycle.
- While out_valid & !out_ready: in_ready = 0 and the FSM holds.
- Output fields are stable while out_valid & !out_ready.
- rst_n asserted mid-sequence clears the FSM and the output immediately, independent of clk. The table is also cleared.
- cfg_we is accepted every cycle regardless of handshake state.

## Test plan
- Reset: after rst_n deasserts → out_valid = 0, in_ready = 1. Lookup of byte 90 → out_class = 0, out_null = 1, out_nbytes = 1.
- Program map 1, entry 05 = {class 0x21, modrm 0, imm 0}. Send 0F, 05 on consecutive cycles → one record, one cycle after byte 05: out_map = 1, out_opcode = 05, out_class = 0x21, out_nbytes = 2.
- Program map 2, entry 00 = {0x40, 1, 0} and map 3, entry 0F = {0x41, 1, 1}. Send 0F 38 00 0F 3A 0F → exactly two records: (2, 00, 0x40, nbytes 3) then (3, 0F, 0x41, imm 1). With ESC_EN = 0, the 0F 38 pair instead yields map 1, opcode 38.
- Backpressure: out_ready = 0 for 3 cycles with the record pending → in_ready = 0 and outputs stable. A stream of 4 one-byte opcodes under random out_ready produces 4 in-order records, with none lost or duplicated.
- Flush after 0F, then send 05 → record shows map 0, opcode 05, nbytes 1. Separately, flush with out_valid = 1 → out_valid = 0 next cycle.
- Write hazard: cfg_we to map 0, entry 90 with class 0x33 in the same cycle as byte 90 is accepted → record has the old class 0. The next 90 → class 0x33.
- Async reset mid-sequence (after 0F) → outputs 0 immediately. Then 05 → map 0, and out_class = 0 because the table was cleared.

Source files
------------

// File: rtl/opcode_map_lookup.sv
// x86 opcode-map decode: tracks 0F/0F38/0F3A escapes and looks up a programmable 4x256 table.
// Latency: one registered record, visible the cycle after the final opcode byte is accepted.
// Backpressure: in_ready = !out_valid | out_ready; a stalled record holds its fields and the FSM.
module opcode_map_lookup #(
  parameter int CLASS_W = 8,
  parameter bit ESC_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_byte,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_map,
  input  logic [7:0]         cfg_opcode,
  input  logic [CLASS_W-1:0] cfg_class,
  input  logic               cfg_modrm,
  input  logic [1:0]         cfg_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [1:0]         out_map,
  output logic [7:0]         out_opcode,
  output logic [CLASS_W-1:0] out_class,
  output logic               out_modrm,
  output logic [1:0]         out_imm,
  output logic [1:0]         out_nbytes,
  output logic               out_null
);

  typedef enum logic [1:0] {S_OP, S_0F, S_38, S_3A} state_t;

  typedef struct packed {
    logic [CLASS_W-1:0] cls;
    logic               modrm;
    logic [1:0]         imm;
  } entry_t;

  entry_t     tbl [1024];
  state_t     state, state_nxt;
  logic       accept;
  logic       lk_vld;
  logic [1:0] lk_map;
  logic [1:0] lk_nbytes;
  entry_t     lk_ent;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Table is indexed {map, opcode}; a same-cycle read sees the pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) tbl[i] <= '0;
    end else if (cfg_we) begin
      tbl[{cfg_map, cfg_opcode}] <= '{cls: cfg_class, modrm: cfg_modrm, imm: cfg_imm};
    end
  end

  assign lk_ent = tbl[{lk_map, in_byte}];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_OP;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    lk_vld    = 1'b0;
    lk_map    = 2'd0;
    lk_nbytes = 2'd0;
    if (accept) begin
      unique case (state)
        S_OP: begin
          if (in_byte == 8'h0F) begin
            state_nxt = S_0F;
          end else begin
            lk_vld    = 1'b1;
            lk_map    = 2'd0;
            lk_nbytes = 2'd1;
          end
        end
        S_0F: begin
          // A second 0F is an ordinary map-1 opcode, not another escape.
          if (ESC_EN && in_byte == 8'h38) begin
            state_nxt = S_38;
          end else if (ESC_EN && in_byte == 8'h3A) begin
            state_nxt = S_3A;
          end else begin
            state_nxt = S_OP;
            lk_vld    = 1'b1;
            lk_map    = 2'd1;
            lk_nbytes = 2'd2;
          end
        end
        S_38: begin
          state_nxt = S_OP;
          lk_vld    = 1'b1;
          lk_map    = 2'd2;
          lk_nbytes = 2'd3;
        end
        S_3A: begin
          state_nxt = S_OP;
          lk_vld    = 1'b1;
          lk_map    = 2'd3;
          lk_nbytes = 2'd3;
        end
        default: state_nxt = S_OP;
      endcase
    end
    if (flush) state_nxt = S_OP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_map    <= 2'd0;
      out_opcode <= 8'd0;
      out_class  <= '0;
      out_modrm  <= 1'b0;
      out_imm    <= 2'd0;
      out_nbytes <= 2'd0;
      out_null   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (lk_vld) begin
      out_valid  <= 1'b1;
      out_map    <= lk_map;
      out_opcode <= in_byte;
      out_class  <= lk_ent.cls;
      out_modrm  <= lk_ent.modrm;
      out_imm    <= lk_ent.imm;
      out_nbytes <= lk_nbytes;
      out_null   <= (lk_ent.cls == '0);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_opcode_map_lookup.sv
// Directed bench for opcode_map_lookup; a second instance with ESC_EN=0 shares the stimulus.
module tb_opcode_map_lookup;
  localparam int CW = 8;

  logic          clk, rst_n, flush, in_valid, in_ready, cfg_we, cfg_modrm;
  logic          out_valid, out_ready, out_modrm, out_null;
  logic [7:0]    in_byte, cfg_opcode, out_opcode;
  logic [1:0]    cfg_map, cfg_imm, out_map, out_imm, out_nbytes;
  logic [CW-1:0] cfg_class, out_class;

  logic          e_in_ready, e_out_valid, e_out_modrm, e_out_null;
  logic [7:0]    e_out_opcode;
  logic [1:0]    e_out_map, e_out_imm, e_out_nbytes;
  logic [CW-1:0] e_out_class;

  int errors = 0;
  int checks = 0;

  opcode_map_lookup #(.CLASS_W(CW), .ESC_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .cfg_we(cfg_we), .cfg_map(cfg_map), .cfg_opcode(cfg_opcode),
    .cfg_class(cfg_class), .cfg_modrm(cfg_modrm), .cfg_imm(cfg_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_map(out_map),
    .out_opcode(out_opcode), .out_class(out_class), .out_modrm(out_modrm),
    .out_imm(out_imm), .out_nbytes(out_nbytes), .out_null(out_null)
  );

  opcode_map_lookup #(.CLASS_W(CW), .ESC_EN(1'b0)) u_dut_noesc (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(e_in_ready), .in_byte(in_byte),
    .cfg_we(cfg_we), .cfg_map(cfg_map), .cfg_opcode(cfg_opcode),
    .cfg_class(cfg_class), .cfg_modrm(cfg_modrm), .cfg_imm(cfg_imm),
    .out_valid(e_out_valid), .out_ready(out_ready), .out_map(e_out_map),
    .out_opcode(e_out_opcode), .out_class(e_out_class), .out_modrm(e_out_modrm),
    .out_imm(e_out_imm), .out_nbytes(e_out_nbytes), .out_null(e_out_null)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    step();
    in_valid = 1'b0;
  endtask

  task automatic cfg(input logic [1:0] m, input logic [7:0] op, input logic [7:0] c,
                     input logic mr, input logic [1:0] im);
    cfg_we     = 1'b1;
    cfg_map    = m;
    cfg_opcode = op;
    cfg_class  = c;
    cfg_modrm  = mr;
    cfg_imm    = im;
    step();
    cfg_we = 1'b0;
  endtask

  localparam logic [7:0] ESC_B [6] = '{8'h0F, 8'h38, 8'h00, 8'h0F, 8'h3A, 8'h0F};
  localparam logic [5:0] EXP_V  = 6'b100100;  // bit i: record after byte i, ESC_EN=1
  localparam logic [5:0] EXP_EV = 6'b010110;  // same for ESC_EN=0
  localparam logic [7:0] STR_B [4] = '{8'h01, 8'h02, 8'h03, 8'h04};

  initial begin
    int nrec, idx, rcv, cyc;
    logic acc;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_map = 2'd0; cfg_opcode = 8'h00; cfg_class = '0; cfg_modrm = 1'b0; cfg_imm = 2'd0;
    step(); step();
    rst_n = 1'b1;
    step();

    // Reset state
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_nbytes", out_nbytes, 0);
    chk("rst_null", out_null, 0);
    chk("rst_opcode", out_opcode, 0);
    send(8'h90);
    chk("nop_valid", out_valid, 1);
    chk("nop_class", out_class, 0);
    chk("nop_null", out_null, 1);
    chk("nop_nbytes", out_nbytes, 1);
    chk("nop_opcode", out_opcode, 8'h90);
    step();
    chk("nop_drain", out_valid, 0);

    // Two-byte map
    cfg(2'd1, 8'h05, 8'h21, 1'b0, 2'd0);
    send(8'h0F);
    chk("esc0f_noout", out_valid, 0);
    send(8'h05);
    chk("m1_valid", out_valid, 1);
    chk("m1_map", out_map, 1);
    chk("m1_opcode", out_opcode, 8'h05);
    chk("m1_class", out_class, 8'h21);
    chk("m1_nbytes", out_nbytes, 2);

    // Three-byte maps, and ESC_EN=0 behaviour on the same stream
    cfg(2'd2, 8'h00, 8'h40, 1'b1, 2'd0);
    cfg(2'd3, 8'h0F, 8'h41, 1'b1, 2'd1);
    nrec = 0;
    for (int i = 0; i < 6; i++) begin
      send(ESC_B[i]);
      chk("esc_vld", out_valid, EXP_V[i]);
      chk("noesc_vld", e_out_valid, EXP_EV[i]);
      if (out_valid) nrec++;
      if (i == 1) begin
        chk("noesc_map", e_out_map, 1);
        chk("noesc_opcode", e_out_opcode, 8'h38);
        chk("noesc_nbytes", e_out_nbytes, 2);
      end
      if (i == 2) begin
        chk("m2_map", out_map, 2);
        chk("m2_opcode", out_opcode, 8'h00);
        chk("m2_class", out_class, 8'h40);
        chk("m2_modrm", out_modrm, 1);
        chk("m2_nbytes", out_nbytes, 3);
      end
      if (i == 5) begin
        chk("m3_map", out_map, 3);
        chk("m3_opcode", out_opcode, 8'h0F);
        chk("m3_class", out_class, 8'h41);
        chk("m3_imm", out_imm, 1);
        chk("m3_nbytes", out_nbytes, 3);
      end
    end
    chk("esc_count", nrec, 2);
    flush = 1'b1;
    step();
    flush = 1'b0;

    // Backpressure stall and same-cycle replace
    cfg(2'd0, 8'h01, 8'h11, 1'b0, 2'd0);
    cfg(2'd0, 8'h02, 8'h12, 1'b0, 2'd1);
    cfg(2'd0, 8'h03, 8'h13, 1'b1, 2'd2);
    cfg(2'd0, 8'h04, 8'h14, 1'b1, 2'd3);
    out_ready = 1'b0;
    send(8'h01);
    chk("bp_valid", out_valid, 1);
    in_valid = 1'b1;
    in_byte  = 8'h02;
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", in_ready, 0);
      step();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_opcode", out_opcode, 8'h01);
      chk("bp_hold_class", out_class, 8'h11);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("bp_replace_valid", out_valid, 1);
    chk("bp_replace_opcode", out_opcode, 8'h02);
    step();
    chk("bp_drain", out_valid, 0);

    // Four-byte stream under random out_ready
    idx = 0; rcv = 0; cyc = 0;
    while (rcv < 4 && cyc < 200) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (idx < 4);
      in_byte   = (idx < 4) ? STR_B[idx] : 8'h00;
      #1;
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        chk("str_opcode", out_opcode, STR_B[rcv]);
        chk("str_class", out_class, 32'h11 + rcv);
        rcv++;
      end
      @(posedge clk);
      if (acc) idx++;
      #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("str_count", rcv, 4);
    chk("str_no_extra", out_valid, 0);

    // Flush mid-escape; cfg write during flush still lands
    send(8'h0F);
    flush = 1'b1; in_valid = 1'b1; in_byte = 8'h05;
    cfg_we = 1'b1; cfg_map = 2'd0; cfg_opcode = 8'h06; cfg_class = 8'h55; cfg_modrm = 1'b0; cfg_imm = 2'd0;
    step();
    flush = 1'b0; in_valid = 1'b0; cfg_we = 1'b0;
    chk("flush_drop", out_valid, 0);
    send(8'h05);
    chk("flush_map", out_map, 0);
    chk("flush_opcode", out_opcode, 8'h05);
    chk("flush_nbytes", out_nbytes, 1);
    send(8'h06);
    chk("flush_cfg_class", out_class, 8'h55);
    out_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_clear_valid", out_valid, 0);
    out_ready = 1'b1;

    // Write/lookup hazard on the same entry
    cfg_we = 1'b1; cfg_map = 2'd0; cfg_opcode = 8'h90; cfg_class = 8'h33; cfg_modrm = 1'b0; cfg_imm = 2'd0;
    send(8'h90);
    cfg_we = 1'b0;
    chk("haz_old_class", out_class, 0);
    chk("haz_old_null", out_null, 1);
    send(8'h90);
    chk("haz_new_class", out_class, 8'h33);
    chk("haz_new_null", out_null, 0);

    // Asynchronous reset mid-sequence clears FSM, outputs and table
    send(8'h0F);
    chk("pre_rst_opcode", out_opcode, 8'h90);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_opcode", out_opcode, 0);
    chk("arst_class", out_class, 0);
    chk("arst_nbytes", out_nbytes, 0);
    chk("arst_null", out_null, 0);
    #1;
    rst_n = 1'b1;
    send(8'h05);
    chk("post_rst_map", out_map, 0);
    chk("post_rst_nbytes", out_nbytes, 1);
    chk("post_rst_class", out_class, 0);
    send(8'h0F);
    send(8'h05);
    chk("post_rst_m1_map", out_map, 1);
    chk("post_rst_m1_class", out_class, 0);
    chk("post_rst_m1_null", out_null, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
